// File: rtl/ftc_link_arb.sv
// ftc_link_arb - round-robin arbiter/sequencer feeding one FTC-coded link.
//
// Picks one of NREQ requesters, forwards its DW-bit words as bursts of at most
// MAX_BURST beats, inserts GAP_CYCLES idle cycles between bursts and gates
// every beat on a credit held against the receive-side decoder buffer.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   per-requester word valid
//   req_data    requester i word at [i*DW +: DW]
//   req_last    current word ends the requester's packet
//   req_ready   one-hot or zero; word accepted when valid & ready
//   enc_data    registered word to the encoder
//   enc_valid   enc_data carries a new word this cycle (one cycle per word)
//   enc_src     index of the requester that sourced enc_data (holds)
//   credit_ret  one word drained from the receive buffer
//   credits     current credit count
//   busy        FSM not idle
//
// Build option: define FTC_IDLE_HOLD_EN to keep enc_data at the last
// transmitted word while enc_valid is low; otherwise it reads 0 when idle.

module ftc_link_arb #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CREDITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        enc_data,
  output logic                 enc_valid,
  output logic [2:0]           enc_src,
  input  logic                 credit_ret,
  output logic [3:0]           credits,
  output logic                 busy
);

  localparam logic [3:0] CreditsMax = 4'(CREDITS);
  localparam logic [3:0] BurstMax   = 4'(MAX_BURST);
  localparam logic [3:0] NreqW      = 4'(NREQ);
  localparam logic [2:0] LastIdx    = 3'(NREQ - 1);
  localparam logic [2:0] GapLast    = (GAP_CYCLES == 0) ? 3'd0 : 3'(GAP_CYCLES - 1);
  localparam bit         HasGap     = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    rr_q, rr_d;
  logic [3:0]    beat_q, beat_d;
  logic [2:0]    gap_q, gap_d;
  logic [3:0]    credits_q, credits_d;
  logic [DW-1:0] enc_data_q, enc_data_d;
  logic          enc_valid_q, enc_valid_d;
  logic [2:0]    enc_src_q, enc_src_d;

  // Zero-extended to 8 so a 3-bit index is always in range.
  logic [7:0]    valid_ext, last_ext;
  logic [DW-1:0] sel_data;
  logic [2:0]    pick;
  logic          pick_found;
  logic [3:0]    cand;
  logic          hs;
  logic          burst_end;
  logic          ret_ok;

  assign valid_ext = 8'(req_valid);
  assign last_ext  = 8'(req_last);

  // Word of the granted requester.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) sel_data = req_data[i*DW +: DW];
    end
  end

  // First valid requester searching upward from the rr pointer, with wrap.
  always_comb begin
    pick       = rr_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= NreqW) cand = cand - NreqW;
      if (!pick_found && valid_ext[cand[2:0]]) begin
        pick       = cand[2:0];
        pick_found = 1'b1;
      end
    end
  end

  assign hs        = (state_q == StXfer) && (credits_q != 4'd0) && valid_ext[grant_q];
  assign burst_end = hs && (last_ext[grant_q] || ((beat_q + 4'd1) == BurstMax));
  // A return while already full is spurious: the buffer is empty.
  assign ret_ok    = credit_ret && (credits_q != CreditsMax);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_q        <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      credits_q   <= CreditsMax;
      enc_data_q  <= '0;
      enc_valid_q <= 1'b0;
      enc_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      credits_q   <= credits_d;
      enc_data_q  <= enc_data_d;
      enc_valid_q <= enc_valid_d;
      enc_src_q   <= enc_src_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Stalls on missing valid or zero credits simply hold the grant.
        if (hs) begin
          beat_d = beat_q + 4'd1;
          if (burst_end) begin
            rr_d    = (grant_q == LastIdx) ? 3'd0 : grant_q + 3'd1;
            beat_d  = '0;
            gap_d   = '0;
            state_d = HasGap ? StGap : StIdle;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: credits and the registered encoder word.
  always_comb begin
    credits_d   = credits_q - {3'b000, hs} + {3'b000, ret_ok};
    enc_valid_d = hs;
    enc_src_d   = hs ? grant_q : enc_src_q;
`ifdef FTC_IDLE_HOLD_EN
    enc_data_d  = hs ? sel_data : enc_data_q;
`else
    enc_data_d  = hs ? sel_data : '0;
`endif
  end

  // Outputs.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == StXfer) && (grant_q == 3'(i)) && (credits_q != 4'd0);
    end
    busy      = (state_q != StIdle);
    credits   = credits_q;
    enc_data  = enc_data_q;
    enc_valid = enc_valid_q;
    enc_src   = enc_src_q;
  end

endmodule
